// File: rtl/umicro_sequencer.sv
// umicro_sequencer: ARC control-store sequencer with CSAR/MIR, COND branching,
// decode dispatch and a memory-wait handshake.
module umicro_sequencer #(
    parameter int DATAWIDTH_MIR = 41,
    parameter int DATAWIDTH_CS_ADDR = 11,
    parameter int DATAWIDTH_REG_SEL = 6,
    parameter int DATAWIDTH_ALU_SEL = 4
) (
    input  logic                         uMicroSeq_CLOCK_50,
    input  logic                         uMICROSEQ_RESET_InHigh,
    output logic [DATAWIDTH_CS_ADDR-1:0] uMicroSeq_CS_Addr_Out,
    input  logic [DATAWIDTH_MIR-1:0]     uMicroSeq_CS_Data_In,
    input  logic                         uMicroSeq_Negative_InLow,
    input  logic                         uMicroSeq_Zero_InLow,
    input  logic                         uMicroSeq_Overflow_InLow,
    input  logic                         uMicroSeq_Carry_InLow,
    input  logic [7:0]                   uMicroSeq_op_In,
    input  logic                         uMicroSeq_IR13_In,
    input  logic                         uMicroSeq_Mem_Ready_In,
    output logic [DATAWIDTH_REG_SEL-1:0] uMicroSeq_A_MUX_MIR_Bus,
    output logic [DATAWIDTH_REG_SEL-1:0] uMicroSeq_B_MUX_MIR_Bus,
    output logic [DATAWIDTH_REG_SEL-1:0] uMicroSeq_C_MUX_MIR_Bus,
    output logic                         uMicroSeq_A_Select_MUX_MIR,
    output logic                         uMicroSeq_B_Select_MUX_MIR,
    output logic                         uMicroSeq_C_Select_MUX_MIR,
    output logic [DATAWIDTH_ALU_SEL-1:0] uMicroSeq_ALUSelection_Out,
    output logic                         uMicroSeq_RD_Out,
    output logic                         uMicroSeq_WR_Out,
    output logic                         uMicroSeq_C_Write_Enable_Out,
    output logic                         uMicroSeq_Set_Codes_Out
);
    typedef enum logic [1:0] {LOAD, EXEC, WAIT} state_t;
    state_t state_q, state_d;
    logic [DATAWIDTH_CS_ADDR-1:0] csar_q, csar_d, next_addr;
    logic [DATAWIDTH_MIR-1:0] mir_q, mir_d;
    logic mir_rd, mir_wr, mem_op, done, taken;
    logic [2:0] cond;
    logic [7:0] cond_hit;

    assign uMicroSeq_A_MUX_MIR_Bus    = mir_q[40:35];
    assign uMicroSeq_A_Select_MUX_MIR = mir_q[34];
    assign uMicroSeq_B_MUX_MIR_Bus    = mir_q[33:28];
    assign uMicroSeq_B_Select_MUX_MIR = mir_q[27];
    assign uMicroSeq_C_MUX_MIR_Bus    = mir_q[26:21];
    assign uMicroSeq_C_Select_MUX_MIR = mir_q[20];
    assign uMicroSeq_ALUSelection_Out = mir_q[17:14];
    assign uMicroSeq_CS_Addr_Out      = csar_q;
    assign mir_rd = mir_q[19];
    assign mir_wr = mir_q[18];
    assign cond   = mir_q[13:11];
    assign mem_op = mir_rd | mir_wr;
    // Bit i is the branch condition for COND=i; flags arrive active-low.
    assign cond_hit = {2'b11, uMicroSeq_IR13_In, ~uMicroSeq_Carry_InLow, ~uMicroSeq_Overflow_InLow,
                       ~uMicroSeq_Zero_InLow, ~uMicroSeq_Negative_InLow, 1'b0};
    assign taken = cond_hit[cond];
    assign next_addr = (cond == 3'd7) ? {1'b1, uMicroSeq_op_In, 2'b00}
                     : taken ? mir_q[10:0] : csar_q + 1'b1;
    // Illegal RD+WR microwords are treated as reads only.
    assign uMicroSeq_RD_Out = (state_q != LOAD) & mir_rd;
    assign uMicroSeq_WR_Out = (state_q != LOAD) & mir_wr & ~mir_rd;
    assign uMicroSeq_C_Write_Enable_Out = done & ~uMICROSEQ_RESET_InHigh & (|mir_q[26:21]);
    assign uMicroSeq_Set_Codes_Out = done & ~uMICROSEQ_RESET_InHigh & (mir_q[17:14] < 4'd4);

    always_comb begin
        state_d = state_q;
        mir_d = mir_q;
        done = 1'b0;
        case (state_q)
            LOAD: begin
                mir_d = uMicroSeq_CS_Data_In;
                state_d = EXEC;
            end
            EXEC: begin
                done = ~mem_op;
                state_d = mem_op ? WAIT : LOAD;
            end
            WAIT: begin
                done = uMicroSeq_Mem_Ready_In;
                state_d = uMicroSeq_Mem_Ready_In ? LOAD : WAIT;
            end
            default: state_d = LOAD;
        endcase
        csar_d = done ? next_addr : csar_q;
    end

    always_ff @(posedge uMicroSeq_CLOCK_50) begin
        if (uMICROSEQ_RESET_InHigh) begin
            state_q <= LOAD;
            csar_q <= '0;
            mir_q <= '0;
        end else begin
            state_q <= state_d;
            csar_q <= csar_d;
            mir_q <= mir_d;
        end
    end
endmodule

// File: tb/tb_umicro_sequencer.sv
// tb_umicro_sequencer: table-driven per-cycle checks against a behavioural ROM,
// plus hand sequences for RD+WR microwords and reset during WAIT.
module tb_umicro_sequencer;
    logic clk = 1'b0, rst = 1'b1;
    logic nl = 1'b1, zl = 1'b1, vl = 1'b1, cl = 1'b1, ir13 = 1'b0, rdy = 1'b0;
    logic [7:0] op = 8'h90;
    logic [10:0] addr;
    logic [40:0] cs_data;
    logic [5:0] abus, bbus, cbus;
    logic asel, bsel, csel, rd, wr, cwe, sc;
    logic [3:0] alu;
    logic [40:0] rom [0:2047];
    int passed = 0, total = 0;

    typedef struct {
        logic rst, zl, nl, rdy;
        logic [10:0] addr;
        logic rd, wr, cwe, sc;
        logic [5:0] cbus, abus;
    } vec_t;
    vec_t v [22];

    always #5 clk = ~clk;
    assign cs_data = rom[addr];

    umicro_sequencer dut (
        .uMicroSeq_CLOCK_50(clk), .uMICROSEQ_RESET_InHigh(rst),
        .uMicroSeq_CS_Addr_Out(addr), .uMicroSeq_CS_Data_In(cs_data),
        .uMicroSeq_Negative_InLow(nl), .uMicroSeq_Zero_InLow(zl),
        .uMicroSeq_Overflow_InLow(vl), .uMicroSeq_Carry_InLow(cl),
        .uMicroSeq_op_In(op), .uMicroSeq_IR13_In(ir13), .uMicroSeq_Mem_Ready_In(rdy),
        .uMicroSeq_A_MUX_MIR_Bus(abus), .uMicroSeq_B_MUX_MIR_Bus(bbus),
        .uMicroSeq_C_MUX_MIR_Bus(cbus), .uMicroSeq_A_Select_MUX_MIR(asel),
        .uMicroSeq_B_Select_MUX_MIR(bsel), .uMicroSeq_C_Select_MUX_MIR(csel),
        .uMicroSeq_ALUSelection_Out(alu), .uMicroSeq_RD_Out(rd), .uMicroSeq_WR_Out(wr),
        .uMicroSeq_C_Write_Enable_Out(cwe), .uMicroSeq_Set_Codes_Out(sc)
    );

    function automatic logic [40:0] mw(input logic [5:0] a, b, c, input logic r, w,
                                       input logic [3:0] al, input logic [2:0] cd,
                                       input logic [10:0] j);
        return {a, 1'b0, b, 1'b0, c, 1'b0, r, w, al, cd, j};
    endfunction

    function automatic vec_t mk(input logic r, z, n, y, input logic [10:0] ad,
                                input logic erd, ewr, ecwe, esc, input logic [5:0] ec, ea);
        vec_t t;
        t.rst = r; t.zl = z; t.nl = n; t.rdy = y; t.addr = ad;
        t.rd = erd; t.wr = ewr; t.cwe = ecwe; t.sc = esc; t.cbus = ec; t.abus = ea;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = '0;
        rom[0]     = mw(0, 0, 0, 0, 0, 4'd5, 3'd0, 11'd0);
        rom[1]     = mw(1, 2, 3, 0, 0, 4'd0, 3'd0, 11'd0);
        rom[2]     = mw(0, 0, 0, 0, 0, 4'd5, 3'd2, 11'h040);
        rom[11'h040] = mw(0, 0, 0, 0, 0, 4'd5, 3'd6, 11'd2);
        rom[3]     = mw(0, 0, 5, 1, 0, 4'd5, 3'd7, 11'd0);
        rom[11'h640] = mw(0, 0, 0, 0, 0, 4'd5, 3'd1, 11'd2047);
        rom[2047]  = mw(0, 0, 0, 0, 0, 4'd5, 3'd0, 11'd0);
        //        rst zl nl rdy  addr    rd wr cwe sc cbus abus
        v[0]  = mk(1, 1, 1, 0, 11'd0,    0, 0, 0, 0, 0, 0);
        v[1]  = mk(0, 1, 1, 0, 11'd0,    0, 0, 0, 0, 0, 0);
        v[2]  = mk(0, 1, 1, 0, 11'd0,    0, 0, 0, 0, 0, 0);
        v[3]  = mk(0, 1, 1, 0, 11'd1,    0, 0, 0, 0, 0, 0);
        v[4]  = mk(0, 1, 1, 0, 11'd1,    0, 0, 1, 1, 3, 1);
        v[5]  = mk(0, 0, 1, 0, 11'd2,    0, 0, 0, 0, 3, 1);
        v[6]  = mk(0, 0, 1, 0, 11'd2,    0, 0, 0, 0, 0, 0);
        v[7]  = mk(0, 1, 1, 0, 11'h040,  0, 0, 0, 0, 0, 0);
        v[8]  = mk(0, 1, 1, 0, 11'h040,  0, 0, 0, 0, 0, 0);
        v[9]  = mk(0, 1, 1, 0, 11'd2,    0, 0, 0, 0, 0, 0);
        v[10] = mk(0, 1, 1, 0, 11'd2,    0, 0, 0, 0, 0, 0);
        v[11] = mk(0, 1, 1, 1, 11'd3,    0, 0, 0, 0, 0, 0);
        v[12] = mk(0, 1, 1, 0, 11'd3,    1, 0, 0, 0, 5, 0);
        v[13] = mk(0, 1, 1, 0, 11'd3,    1, 0, 0, 0, 5, 0);
        v[14] = mk(0, 1, 1, 0, 11'd3,    1, 0, 0, 0, 5, 0);
        v[15] = mk(0, 1, 1, 0, 11'd3,    1, 0, 0, 0, 5, 0);
        v[16] = mk(0, 1, 1, 1, 11'd3,    1, 0, 1, 0, 5, 0);
        v[17] = mk(0, 1, 1, 0, 11'h640,  0, 0, 0, 0, 5, 0);
        v[18] = mk(0, 1, 0, 0, 11'h640,  0, 0, 0, 0, 0, 0);
        v[19] = mk(0, 1, 1, 0, 11'd2047, 0, 0, 0, 0, 0, 0);
        v[20] = mk(0, 1, 1, 0, 11'd2047, 0, 0, 0, 0, 0, 0);
        v[21] = mk(0, 1, 1, 0, 11'd0,    0, 0, 0, 0, 0, 0);
        @(posedge clk);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            rst = v[i].rst; zl = v[i].zl; nl = v[i].nl; rdy = v[i].rdy;
            #1;
            chk($sformatf("v%0d addr", i), addr, v[i].addr);
            chk($sformatf("v%0d rd", i), rd, v[i].rd);
            chk($sformatf("v%0d wr", i), wr, v[i].wr);
            chk($sformatf("v%0d cwe", i), cwe, v[i].cwe);
            chk($sformatf("v%0d sc", i), sc, v[i].sc);
            chk($sformatf("v%0d cbus", i), cbus, v[i].cbus);
            chk($sformatf("v%0d abus", i), abus, v[i].abus);
        end
        // RD+WR microword behaves as a read; then a write is cut off by reset in WAIT.
        rom[0] = mw(0, 0, 7, 1, 1, 4'd2, 3'd6, 11'd5);
        rom[5] = mw(0, 0, 4, 0, 1, 4'd5, 3'd0, 11'd0);
        @(negedge clk); rst = 1; rdy = 0;
        @(negedge clk); rst = 0; #1;
        chk("rw load rd", rd, 0);
        @(negedge clk); #1;
        chk("rw exec rd", rd, 1);
        chk("rw exec wr", wr, 0);
        chk("rw exec cwe", cwe, 0);
        @(negedge clk); rdy = 1; #1;
        chk("rw wait wr", wr, 0);
        chk("rw done cwe", cwe, 1);
        chk("rw done sc", sc, 1);
        @(negedge clk); rdy = 0; #1;
        chk("rw next addr", addr, 5);
        @(negedge clk); #1;
        chk("wr exec wr", wr, 1);
        chk("wr exec rd", rd, 0);
        @(negedge clk); #1;
        chk("wr wait wr", wr, 1);
        chk("wr wait addr", addr, 5);
        @(negedge clk); rst = 1; rdy = 1; #1;
        chk("rst wait cwe", cwe, 0);
        @(negedge clk); rst = 0; rdy = 0; #1;
        chk("rst addr", addr, 0);
        chk("rst rd", rd, 0);
        chk("rst wr", wr, 0);
        chk("rst cwe", cwe, 0);
        chk("rst cbus", cbus, 0);
        @(negedge clk); #1;
        chk("rst then exec rd", rd, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
